// File: rtl/video_bram_pkg.sv
// Shared definitions for the VideoIn-to-BRAM capture writer: FSM encoding,
// byte-enable patterns and word geometry.
package video_bram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_FLUSH,
        ST_DONE
    } state_t;

    localparam logic [0:3] WEN_FULL     = 4'b1111;
    localparam logic [0:3] WEN_HI       = 4'b1100;
    localparam int         C_WORD_BYTES = 4;

endpackage

// File: rtl/video_pix_packer.sv
// Pairs 16-bit pixels into big-endian 32-bit words: even pixel in [0:15],
// odd pixel in [16:31]. Word outputs are combinational; the caller registers them.
module video_pix_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        pix_take,
    input  logic        flush,
    input  logic [0:15] pix_data,
    output logic        phase,
    output logic        word_valid,
    output logic        word_half,
    output logic [0:31] word_data
);

    logic [0:15] even_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= 1'b0;
            even_q <= '0;
        end else if (clr || flush) begin
            phase  <= 1'b0;
        end else if (pix_take) begin
            if (!phase)
                even_q <= pix_data;
            phase <= ~phase;
        end
    end

    // A flush only completes a word when an even pixel is pending.
    assign word_valid = phase & (pix_take | flush);
    assign word_half  = flush;
    assign word_data  = {even_q, (flush ? 16'h0000 : pix_data)};

endmodule

// File: rtl/video_bram_capture_writer.sv
// Captures one armed VideoIn frame into BRAM port B as packed 32-bit words,
// stopping at end of frame, at a premature SOF, or when the buffer is full.
module video_bram_capture_writer
    import video_bram_pkg::*;
#(
    parameter logic [0:31] C_BASEADDR    = 32'h0000_0000,
    parameter int          C_MEMSIZE     = 'h8000,
    parameter int          C_PORT_DWIDTH = 32,
    parameter int          C_NUM_WE      = 4
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     Capture_Start,
    input  logic                     Pix_Valid,
    input  logic [0:15]              Pix_Data,
    input  logic                     Pix_Sof,
    input  logic                     Pix_Eof,
    output logic                     BRAM_Clk,
    output logic                     BRAM_Rst,
    output logic                     BRAM_EN,
    output logic [0:C_NUM_WE-1]      BRAM_WEN,
    output logic [0:31]              BRAM_Addr,
    output logic [0:C_PORT_DWIDTH-1] BRAM_Dout,
    input  logic [0:C_PORT_DWIDTH-1] BRAM_Din,
    output logic                     Capture_Busy,
    output logic                     Capture_Done,
    output logic                     Truncated,
    output logic [0:15]              Word_Count
);

    localparam logic [0:31] LAST_ADDR = C_BASEADDR + 32'(C_MEMSIZE - C_WORD_BYTES);

    state_t      state;
    logic [0:31] wr_addr;
    logic [1:0]  rst_sync;
    logic        rst_int_n;
    logic        arm, pix_take, flush;
    logic        pix_phase, word_valid, word_half;
    logic [0:31] word_data;
    logic        unused_din;

    assign BRAM_Clk   = Clk;
    assign BRAM_Rst   = 1'b0;
    assign unused_din = ^BRAM_Din;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    assign arm      = Capture_Start & ((state == ST_IDLE) | (state == ST_DONE));
    assign pix_take = Pix_Valid & (((state == ST_ARMED) & Pix_Sof) |
                                   ((state == ST_CAPTURE) & ~Pix_Sof));
    assign flush    = (state == ST_FLUSH);

    video_pix_packer u_packer (
        .clk        (Clk),
        .rst_n      (rst_int_n),
        .clr        (arm),
        .pix_take   (pix_take),
        .flush      (flush),
        .pix_data   (Pix_Data),
        .phase      (pix_phase),
        .word_valid (word_valid),
        .word_half  (word_half),
        .word_data  (word_data)
    );

    always_ff @(posedge Clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state        <= ST_IDLE;
            BRAM_EN      <= 1'b0;
            BRAM_WEN     <= '0;
            BRAM_Addr    <= C_BASEADDR;
            BRAM_Dout    <= '0;
            wr_addr      <= C_BASEADDR;
            Capture_Busy <= 1'b0;
            Capture_Done <= 1'b0;
            Truncated    <= 1'b0;
            Word_Count   <= '0;
        end else begin
            BRAM_EN  <= 1'b0;
            BRAM_WEN <= '0;
            if (word_valid) begin
                BRAM_EN    <= 1'b1;
                BRAM_WEN   <= word_half ? WEN_HI : WEN_FULL;
                BRAM_Addr  <= wr_addr;
                BRAM_Dout  <= word_data;
                wr_addr    <= wr_addr + 32'(C_WORD_BYTES);
                Word_Count <= Word_Count + 16'd1;
            end
            // Done trails the DONE state by a cycle so it follows the last strobe.
            if (state == ST_DONE)
                Capture_Done <= 1'b1;

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (Capture_Start) begin
                        state        <= ST_ARMED;
                        Capture_Busy <= 1'b1;
                        Capture_Done <= 1'b0;
                        Truncated    <= 1'b0;
                        Word_Count   <= '0;
                        wr_addr      <= C_BASEADDR;
                    end
                end
                ST_ARMED: begin
                    if (pix_take)
                        state <= Pix_Eof ? ST_FLUSH : ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (Pix_Valid) begin
                        if (Pix_Sof) begin
                            Truncated <= 1'b1;
                            if (pix_phase) begin
                                state <= ST_FLUSH;
                            end else begin
                                state        <= ST_DONE;
                                Capture_Busy <= 1'b0;
                            end
                        end else if (word_valid && wr_addr == LAST_ADDR) begin
                            state        <= ST_DONE;
                            Capture_Busy <= 1'b0;
                            if (!Pix_Eof)
                                Truncated <= 1'b1;
                        end else if (Pix_Eof) begin
                            if (pix_phase) begin
                                state        <= ST_DONE;
                                Capture_Busy <= 1'b0;
                            end else begin
                                state <= ST_FLUSH;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    state        <= ST_DONE;
                    Capture_Busy <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_video_bram_capture_writer.sv
// Directed bench: a 32 KB instance for the functional cases and a 16-byte
// instance for the buffer-full cases, both driven by the same pixel stream.
module tb_video_bram_capture_writer;

    logic        clk, rst_n, cs, pv, ps, pe;
    logic [0:15] pd;
    logic [0:31] din;

    logic        bclk0, brst0, en0, busy0, done0, trunc0;
    logic [0:3]  wen0;
    logic [0:31] addr0, dout0;
    logic [0:15] wc0;
    logic        bclk1, brst1, en1, busy1, done1, trunc1;
    logic [0:3]  wen1;
    logic [0:31] addr1, dout1;
    logic [0:15] wc1;

    int checks = 0;
    int failures = 0;

    logic [31:0] wa0[64], wd0[64], wa1[64], wd1[64];
    logic [3:0]  ww0[64], ww1[64];
    int n0 = 0, n1 = 0;

    video_bram_capture_writer u_dut0 (
        .Clk(clk), .Rst_n(rst_n), .Capture_Start(cs), .Pix_Valid(pv), .Pix_Data(pd),
        .Pix_Sof(ps), .Pix_Eof(pe), .BRAM_Clk(bclk0), .BRAM_Rst(brst0), .BRAM_EN(en0),
        .BRAM_WEN(wen0), .BRAM_Addr(addr0), .BRAM_Dout(dout0), .BRAM_Din(din),
        .Capture_Busy(busy0), .Capture_Done(done0), .Truncated(trunc0), .Word_Count(wc0)
    );

    video_bram_capture_writer #(.C_MEMSIZE('h10)) u_dut1 (
        .Clk(clk), .Rst_n(rst_n), .Capture_Start(cs), .Pix_Valid(pv), .Pix_Data(pd),
        .Pix_Sof(ps), .Pix_Eof(pe), .BRAM_Clk(bclk1), .BRAM_Rst(brst1), .BRAM_EN(en1),
        .BRAM_WEN(wen1), .BRAM_Addr(addr1), .BRAM_Dout(dout1), .BRAM_Din(din),
        .Capture_Busy(busy1), .Capture_Done(done1), .Truncated(trunc1), .Word_Count(wc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log, sampled on the falling edge.
    always @(negedge clk) begin
        if (en0) begin
            if (n0 < 64) begin wa0[n0] = addr0; wd0[n0] = dout0; ww0[n0] = wen0; end
            n0++;
        end
        if (en1) begin
            if (n1 < 64) begin wa1[n1] = addr1; wd1[n1] = dout1; ww1[n1] = wen1; end
            n1++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cs = 0; pv = 0; ps = 0; pe = 0; pd = '0;
        end
    endtask

    task automatic pix(input logic [15:0] d, input logic s, input logic e);
        @(negedge clk);
        cs = 0; pv = 1; pd = d; ps = s; pe = e;
    endtask

    task automatic start();
        @(negedge clk);
        cs = 1; pv = 0; ps = 0; pe = 0;
        @(negedge clk);
        cs = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        idle(2);
        rst_n = 1;
        idle(4);
    endtask

    task automatic test_reset();
        rst_n = 0; cs = 0; pv = 0; ps = 0; pe = 0; pd = '0; din = 32'hDEAD_BEEF;
        idle(3);
        checks++; if (en0 !== 1'b0) begin failures++; $display("FAIL rst_en got=%b exp=0", en0); end
        checks++; if (wen0 !== 4'b0000) begin failures++; $display("FAIL rst_wen got=%b exp=0000", wen0); end
        checks++; if (addr0 !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", addr0); end
        checks++; if (dout0 !== 32'h0) begin failures++; $display("FAIL rst_dout got=%h exp=0", dout0); end
        checks++; if ({busy0, done0, trunc0} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {busy0, done0, trunc0}); end
        checks++; if (wc0 !== 16'h0) begin failures++; $display("FAIL rst_wc got=%h exp=0", wc0); end
        checks++; if (brst0 !== 1'b0) begin failures++; $display("FAIL bram_rst got=%b exp=0", brst0); end
        rst_n = 1;
        idle(4);
        checks++; if ({en0, busy0, done0} !== 3'b000) begin failures++; $display("FAIL post_rst got=%b exp=000", {en0, busy0, done0}); end
    endtask

    task automatic test_even_frame();
        int b = n0;
        start();
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL even_busy got=%b exp=1", busy0); end
        pix(16'h1111, 1, 0); pix(16'h2222, 0, 0); pix(16'h3333, 0, 0); pix(16'h4444, 0, 1);
        idle(1);
        checks++; if ({en0, done0} !== 2'b10) begin failures++; $display("FAIL even_last_strobe got=%b exp=10", {en0, done0}); end
        idle(1);
        checks++; if ({en0, done0, busy0} !== 3'b010) begin failures++; $display("FAIL even_done_rise got=%b exp=010", {en0, done0, busy0}); end
        idle(2);
        checks++; if (n0 - b !== 2) begin failures++; $display("FAIL even_nwr got=%0d exp=2", n0 - b); end
        checks++; if ({wa0[b], wd0[b], ww0[b]} !== {32'h0, 32'h1111_2222, 4'hF}) begin failures++; $display("FAIL even_w0 got=%h/%h/%b exp=0/11112222/1111", wa0[b], wd0[b], ww0[b]); end
        checks++; if ({wa0[b+1], wd0[b+1], ww0[b+1]} !== {32'h4, 32'h3333_4444, 4'hF}) begin failures++; $display("FAIL even_w1 got=%h/%h/%b exp=4/33334444/1111", wa0[b+1], wd0[b+1], ww0[b+1]); end
        checks++; if ({wc0, done0, trunc0} !== {16'd2, 1'b1, 1'b0}) begin failures++; $display("FAIL even_status got=wc%0d d%b t%b exp=wc2 d1 t0", wc0, done0, trunc0); end
    endtask

    task automatic test_odd_frame();
        int b = n0;
        start();
        checks++; if ({done0, wc0} !== {1'b0, 16'd0}) begin failures++; $display("FAIL odd_arm_clear got=d%b wc%0d exp=d0 wc0", done0, wc0); end
        pix(16'hAAAA, 1, 0); pix(16'hBBBB, 0, 0); pix(16'hCCCC, 0, 1);
        idle(1);
        checks++; if ({en0, busy0} !== 2'b01) begin failures++; $display("FAIL odd_flush_state got=%b exp=01", {en0, busy0}); end
        idle(1);
        checks++; if ({en0, wen0, done0} !== {1'b1, 4'b1100, 1'b0}) begin failures++; $display("FAIL odd_half_strobe got=%b/%b/%b exp=1/1100/0", en0, wen0, done0); end
        idle(1);
        checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL odd_done got=%b exp=1", done0); end
        idle(2);
        checks++; if (n0 - b !== 2) begin failures++; $display("FAIL odd_nwr got=%0d exp=2", n0 - b); end
        checks++; if ({wa0[b], wd0[b], ww0[b]} !== {32'h0, 32'hAAAA_BBBB, 4'hF}) begin failures++; $display("FAIL odd_w0 got=%h/%h/%b exp=0/aaaabbbb/1111", wa0[b], wd0[b], ww0[b]); end
        checks++; if ({wa0[b+1], wd0[b+1], ww0[b+1]} !== {32'h4, 32'hCCCC_0000, 4'hC}) begin failures++; $display("FAIL odd_w1 got=%h/%h/%b exp=4/cccc0000/1100", wa0[b+1], wd0[b+1], ww0[b+1]); end
        checks++; if ({wc0, trunc0} !== {16'd2, 1'b0}) begin failures++; $display("FAIL odd_status got=wc%0d t%b exp=wc2 t0", wc0, trunc0); end
    endtask

    task automatic test_sof_before_arm();
        int b;
        do_reset();
        b = n0;
        pix(16'h5555, 1, 0); pix(16'h6666, 0, 1);
        idle(3);
        checks++; if (n0 - b !== 0) begin failures++; $display("FAIL idle_no_write got=%0d exp=0", n0 - b); end
        // Start together with SOF: that SOF is not captured.
        @(negedge clk);
        cs = 1; pv = 1; pd = 16'h7777; ps = 1; pe = 0;
        pix(16'h8888, 0, 1);
        idle(1);
        checks++; if ({busy0, en0} !== 2'b10) begin failures++; $display("FAIL start_sof_armed got=%b exp=10", {busy0, en0}); end
        pix(16'h9999, 1, 0); pix(16'hABCD, 0, 1);
        idle(4);
        checks++; if (n0 - b !== 1) begin failures++; $display("FAIL arm_nwr got=%0d exp=1", n0 - b); end
        checks++; if ({wa0[b], wd0[b]} !== {32'h0, 32'h9999_ABCD}) begin failures++; $display("FAIL arm_w0 got=%h/%h exp=0/9999abcd", wa0[b], wd0[b]); end
    endtask

    task automatic test_full();
        int b0 = n0, b1 = n1;
        start();
        for (int i = 1; i <= 10; i++)
            pix(16'h0100 + 16'(i), i == 1, i == 10);
        idle(4);
        checks++; if (n1 - b1 !== 4) begin failures++; $display("FAIL full_nwr got=%0d exp=4", n1 - b1); end
        for (int k = 0; k < 4; k++) begin
            logic [31:0] ea, ed;
            ea = 32'(4 * k);
            ed = {16'h0101 + 16'(2 * k), 16'h0102 + 16'(2 * k)};
            checks++;
            if ({wa1[b1+k], wd1[b1+k]} !== {ea, ed}) begin
                failures++;
                $display("FAIL full_w%0d got=%h/%h exp=%h/%h", k, wa1[b1+k], wd1[b1+k], ea, ed);
            end
        end
        checks++; if ({wc1, trunc1, done1, busy1} !== {16'd4, 3'b110}) begin failures++; $display("FAIL full_status got=wc%0d t%b d%b b%b exp=wc4 t1 d1 b0", wc1, trunc1, done1, busy1); end
        checks++; if ({n0 - b0, 32'(wc0), 1'(trunc0)} !== {32'd5, 32'd5, 1'b0}) begin failures++; $display("FAIL big_10pix got=n%0d wc%0d t%b exp=n5 wc5 t0", n0 - b0, wc0, trunc0); end
    endtask

    task automatic test_full_eof();
        int b1 = n1;
        start();
        for (int i = 1; i <= 8; i++)
            pix(16'h0200 + 16'(i), i == 1, i == 8);
        idle(4);
        checks++; if (n1 - b1 !== 4) begin failures++; $display("FAIL fulleof_nwr got=%0d exp=4", n1 - b1); end
        checks++; if ({wa1[b1+3], wd1[b1+3]} !== {32'hC, 32'h0207_0208}) begin failures++; $display("FAIL fulleof_last got=%h/%h exp=c/02070208", wa1[b1+3], wd1[b1+3]); end
        checks++; if ({wc1, trunc1, done1} !== {16'd4, 2'b01}) begin failures++; $display("FAIL fulleof_status got=wc%0d t%b d%b exp=wc4 t0 d1", wc1, trunc1, done1); end
    endtask

    task automatic test_sof_restart();
        int b = n0;
        start();
        for (int i = 1; i <= 5; i++)
            pix(16'h0A00 + 16'(i), i == 1, 0);
        pix(16'h0B00, 1, 0);
        idle(5);
        checks++; if (n0 - b !== 3) begin failures++; $display("FAIL restart_nwr got=%0d exp=3", n0 - b); end
        checks++; if ({wa0[b+2], wd0[b+2], ww0[b+2]} !== {32'h8, 32'h0A05_0000, 4'hC}) begin failures++; $display("FAIL restart_flush got=%h/%h/%b exp=8/0a050000/1100", wa0[b+2], wd0[b+2], ww0[b+2]); end
        checks++; if ({wc0, trunc0, done0} !== {16'd3, 2'b11}) begin failures++; $display("FAIL restart_status got=wc%0d t%b d%b exp=wc3 t1 d1", wc0, trunc0, done0); end
    endtask

    task automatic test_reset_mid();
        int b;
        start();
        pix(16'h1234, 1, 0); pix(16'h5678, 0, 0);
        idle(1);
        checks++; if (en0 !== 1'b1) begin failures++; $display("FAIL mid_pre_en got=%b exp=1", en0); end
        #1 rst_n = 0;
        #1;
        checks++; if ({en0, busy0, wc0} !== {2'b00, 16'd0}) begin failures++; $display("FAIL mid_async got=e%b b%b wc%0d exp=e0 b0 wc0", en0, busy0, wc0); end
        idle(2);
        rst_n = 1;
        idle(4);
        b = n0;
        pix(16'h1111, 0, 0); pix(16'h2222, 0, 1);
        idle(3);
        checks++; if ({n0 - b, 1'(busy0)} !== {32'd0, 1'b0}) begin failures++; $display("FAIL mid_idle got=n%0d b%b exp=n0 b0", n0 - b, busy0); end
    endtask

    initial begin
        test_reset();
        test_even_frame();
        test_odd_frame();
        test_sof_before_arm();
        test_full();
        test_full_eof();
        test_sof_restart();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
